screen_sequencer: RTL and testbench

- Top-level screen flow controller for VGA Pong.
- Steps through title, instructions and game screens. Launches the full-screen image blitter and waits for each blit to finish.
- Owns the single VGA adapter write port. Multiplexes it between the blitter pixel stream (latency-aligned) and the game-object drawer.
- Sits between the keys/game logic and the VGA adapter.

---
 rtl/screen_sequencer_if.sv | 25 ++
 rtl/screen_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_screen_sequencer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/screen_sequencer_if.sv
// Blitter control and VGA write-port bundle for the Pong screen sequencer.
// master: the sequencer (drives blitter start/select and the VGA port).
// slave : the blitter/VGA side (drives the blitter pixel stream).
interface screen_sequencer_if;
  logic       scr_enable;
  logic [1:0] select_screen;
  logic       scr_busy;
  logic [9:0] scr_x;
  logic [9:0] scr_y;
  logic [2:0] scr_colour;
  logic       vga_plot;
  logic [9:0] vga_x;
  logic [9:0] vga_y;
  logic [2:0] vga_colour;

  modport master (
    output scr_enable, select_screen, vga_plot, vga_x, vga_y, vga_colour,
    input  scr_busy, scr_x, scr_y, scr_colour
  );

  modport slave (
    input  scr_enable, select_screen, vga_plot, vga_x, vga_y, vga_colour,
    output scr_busy, scr_x, scr_y, scr_colour
  );
endinterface

// File: rtl/screen_sequencer.sv
// Top-level screen flow controller for VGA Pong.
// Walks title -> instructions -> game, launching the full-screen blitter for
// each image and waiting for it to drain, and owns the single VGA write port:
// outside GAME the latency-aligned blitter stream drives it, in GAME the
// game-object drawer does.
module screen_sequencer #(
  parameter int         PIX_LAT   = 2,
  parameter logic [1:0] SCR_TITLE = 2'd0,
  parameter logic [1:0] SCR_INSTR = 2'd1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               key_next,
  input  logic               game_over,
  input  logic               game_plot,
  input  logic [9:0]         game_x,
  input  logic [9:0]         game_y,
  input  logic [2:0]         game_colour,
  output logic               game_grant,
  output logic [2:0]         state,
  screen_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    T_GO   = 3'd0,
    T_DRAW = 3'd1,
    T_SHOW = 3'd2,
    I_GO   = 3'd3,
    I_DRAW = 3'd4,
    I_SHOW = 3'd5,
    GAME   = 3'd6
  } state_e;

  // Drain counter only needs to reach PIX_LAT-1.
  localparam int                 DRAIN_W    = (PIX_LAT > 2) ? $clog2(PIX_LAT) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(PIX_LAT - 1);

  state_e             state_r;
  state_e             next_s;
  logic               key_prev_r;
  logic               key_rise_s;
  logic               in_go_s;
  logic               in_draw_s;
  logic               draw_done_s;
  logic               busy_seen_r;
  logic [DRAIN_W-1:0] drain_r;
  logic               scr_enable_r;
  logic [1:0]         select_r;
  logic               game_grant_r;
  logic               busy_d_r [PIX_LAT];
  logic [9:0]         x_d_r    [PIX_LAT];
  logic [9:0]         y_d_r    [PIX_LAT];
  logic               vga_plot_r;
  logic [9:0]         vga_x_r;
  logic [9:0]         vga_y_r;
  logic [2:0]         vga_colour_r;

  // Decode state classes, the key rising edge and blit completion.
  always_comb begin
    key_rise_s  = key_next & ~key_prev_r;
    in_go_s     = (state_r == T_GO) || (state_r == I_GO);
    in_draw_s   = (state_r == T_DRAW) || (state_r == I_DRAW);
    // Blit finished and the last pixel has left the PIX_LAT pipeline.
    draw_done_s = busy_seen_r && !bus.scr_busy && (drain_r == DRAIN_LAST);
  end

  // Next-state logic; key edges only matter in the SHOW states.
  always_comb begin
    next_s = state_r;
    case (state_r)
      T_GO:    next_s = T_DRAW;
      T_DRAW:  if (draw_done_s) next_s = T_SHOW; else next_s = T_DRAW;
      T_SHOW:  if (key_rise_s)  next_s = I_GO;   else next_s = T_SHOW;
      I_GO:    next_s = I_DRAW;
      I_DRAW:  if (draw_done_s) next_s = I_SHOW; else next_s = I_DRAW;
      I_SHOW:  if (key_rise_s)  next_s = GAME;   else next_s = I_SHOW;
      GAME:    if (game_over)   next_s = T_GO;   else next_s = GAME;
      default: next_s = T_GO;
    endcase
  end

  // State register and key edge history.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r    <= T_GO;
      key_prev_r <= 1'b0;
    end else begin
      state_r    <= next_s;
      key_prev_r <= key_next;
    end
  end

  // Track that the blitter started, then count the pipeline drain cycles.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      busy_seen_r <= 1'b0;
      drain_r     <= '0;
    end else if (in_go_s) begin
      busy_seen_r <= 1'b0;
      drain_r     <= '0;
    end else if (in_draw_s) begin
      if (bus.scr_busy) begin
        busy_seen_r <= 1'b1;
      end
      if (busy_seen_r && !bus.scr_busy) begin
        drain_r <= drain_r + DRAIN_W'(1);
      end
    end else begin
      busy_seen_r <= busy_seen_r;
      drain_r     <= drain_r;
    end
  end

  // Registered control outputs: start pulse, image select, game grant.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      scr_enable_r <= 1'b0;
      select_r     <= SCR_TITLE;
      game_grant_r <= 1'b0;
    end else begin
      // GO lasts exactly one cycle, so this is a single-cycle pulse.
      scr_enable_r <= in_go_s;
      // Select changes only on entry to a GO state, never mid-blit.
      if (next_s == T_GO) begin
        select_r <= SCR_TITLE;
      end else if (next_s == I_GO) begin
        select_r <= SCR_INSTR;
      end else begin
        select_r <= select_r;
      end
      game_grant_r <= (next_s == GAME);
    end
  end

  // Delay blitter busy/x/y so they line up with the late-arriving colour.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < PIX_LAT; i++) begin
        busy_d_r[i] <= 1'b0;
        x_d_r[i]    <= 10'd0;
        y_d_r[i]    <= 10'd0;
      end
    end else begin
      busy_d_r[0] <= bus.scr_busy;
      x_d_r[0]    <= bus.scr_x;
      y_d_r[0]    <= bus.scr_y;
      for (int i = 1; i < PIX_LAT; i++) begin
        busy_d_r[i] <= busy_d_r[i-1];
        x_d_r[i]    <= x_d_r[i-1];
        y_d_r[i]    <= y_d_r[i-1];
      end
    end
  end

  // VGA write port: game drawer in GAME, aligned blitter stream otherwise.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      vga_plot_r   <= 1'b0;
      vga_x_r      <= 10'd0;
      vga_y_r      <= 10'd0;
      vga_colour_r <= 3'd0;
    end else if (state_r == GAME) begin
      vga_plot_r   <= game_plot;
      vga_x_r      <= game_x;
      vga_y_r      <= game_y;
      vga_colour_r <= game_colour;
    end else begin
      vga_plot_r   <= busy_d_r[PIX_LAT-1];
      vga_x_r      <= x_d_r[PIX_LAT-1];
      vga_y_r      <= y_d_r[PIX_LAT-1];
      vga_colour_r <= bus.scr_colour;
    end
  end

  assign bus.scr_enable    = scr_enable_r;
  assign bus.select_screen = select_r;
  assign bus.vga_plot      = vga_plot_r;
  assign bus.vga_x         = vga_x_r;
  assign bus.vga_y         = vga_y_r;
  assign bus.vga_colour    = vga_colour_r;
  assign game_grant        = game_grant_r;
  assign state             = state_r;

endmodule

// File: tb/tb_screen_sequencer.sv
// Self-checking bench for screen_sequencer: a behavioural blitter drives
// full 160x120 raster blits; a monitor compares every VGA write against the
// raster order and a colour rule, and a directed/randomized flow walks the
// screens, the game port, key edges and resets.
module tb_screen_sequencer;

  localparam int NPIX = 19200;

  logic       clk = 1'b0;
  logic       resetn;
  logic       key_next;
  logic       game_over;
  logic       game_plot;
  logic [9:0] game_x;
  logic [9:0] game_y;
  logic [2:0] game_colour;
  logic       game_grant;
  logic [2:0] dut_state;

  screen_sequencer_if bus ();

  screen_sequencer dut (
    .clk         (clk),
    .resetn      (resetn),
    .key_next    (key_next),
    .game_over   (game_over),
    .game_plot   (game_plot),
    .game_x      (game_x),
    .game_y      (game_y),
    .game_colour (game_colour),
    .game_grant  (game_grant),
    .state       (dut_state),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int seed;
  logic [1:0] exp_sel;

  // Reference colour rule: what the image ROM holds at (x,y) for a screen.
  function automatic logic [2:0] pix_colour(input int x, input int y, input int s, input int sd);
    int v;
    v = x * 3 + y * 5 + s * 2 + sd;
    return v[2:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Behavioural blitter: busy one cycle after enable, 19200 raster pixels,
  // colour presented PIX_LAT=2 cycles after its address.
  logic       blt_active = 1'b0;
  logic       blt_pending = 1'b0;
  int         blt_idx = 0;
  logic [1:0] blt_sel = 2'd0;
  logic [2:0] col_h1 = 3'd0;
  logic [2:0] col_h2 = 3'd0;

  initial begin
    bus.scr_busy = 1'b0; bus.scr_x = 10'd0; bus.scr_y = 10'd0; bus.scr_colour = 3'd0;
  end

  always @(negedge clk) begin
    if (!resetn) begin
      blt_active = 1'b0; blt_pending = 1'b0; blt_idx = 0;
      bus.scr_busy = 1'b0; bus.scr_x = 10'd0; bus.scr_y = 10'd0;
      col_h1 = 3'd0; col_h2 = 3'd0; bus.scr_colour = 3'd0;
    end else begin
      if (blt_active) begin
        if (blt_idx == NPIX - 1) begin
          blt_active = 1'b0;
          bus.scr_busy = 1'b0;
        end else begin
          blt_idx++;
          bus.scr_x = 10'(blt_idx % 160);
          bus.scr_y = 10'(blt_idx / 160);
        end
      end else if (blt_pending) begin
        blt_pending = 1'b0; blt_active = 1'b1; blt_idx = 0;
        bus.scr_busy = 1'b1; bus.scr_x = 10'd0; bus.scr_y = 10'd0;
        blt_sel = bus.select_screen;
      end
      bus.scr_colour = col_h2;
      col_h2 = col_h1;
      col_h1 = pix_colour(int'(bus.scr_x), int'(bus.scr_y), int'(blt_sel), seed);
      if (bus.scr_enable) blt_pending = 1'b1;
    end
  end

  // Monitor: per-blit scoreboard against the expected raster sequence.
  int         pix_cnt = 0;
  int         bad_cnt = 0;
  int         en_cnt = 0;
  logic [1:0] en_sel = 2'd0;
  int         first_x = -1, first_y = -1, first_c = -1;
  int         last_x = -1, last_y = -1, last_c = -1;

  always begin
    @(posedge clk);
    #2;
    if (bus.scr_enable) begin
      en_cnt++;
      en_sel  = bus.select_screen;
      pix_cnt = 0;
      bad_cnt = 0;
    end
    if (bus.vga_plot) begin
      if (pix_cnt == 0) begin
        first_x = int'(bus.vga_x); first_y = int'(bus.vga_y); first_c = int'(bus.vga_colour);
      end
      last_x = int'(bus.vga_x); last_y = int'(bus.vga_y); last_c = int'(bus.vga_colour);
      if (pix_cnt >= NPIX || int'(bus.vga_x) != pix_cnt % 160 || int'(bus.vga_y) != pix_cnt / 160 ||
          bus.vga_colour != pix_colour(pix_cnt % 160, pix_cnt / 160, int'(exp_sel), seed))
        bad_cnt++;
      pix_cnt++;
    end
  end

  task automatic wait_state(input logic [2:0] tgt, input int budget, input string tag);
    int n;
    n = 0;
    while (dut_state !== tgt && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(dut_state), 32'(tgt));
  endtask

  task automatic check_blit(input string tag, input logic [1:0] sel, input int en_base);
    check({tag, "_enable_pulses"}, 32'(en_cnt - en_base), 32'd1);
    check({tag, "_enable_select"}, 32'(en_sel), 32'(sel));
    check({tag, "_pixel_count"}, 32'(pix_cnt), 32'(NPIX));
    check({tag, "_pixel_errors"}, 32'(bad_cnt), 32'd0);
    check({tag, "_first_x"}, 32'(first_x), 32'd0);
    check({tag, "_first_y"}, 32'(first_y), 32'd0);
    check({tag, "_first_colour"}, 32'(first_c), 32'(pix_colour(0, 0, int'(sel), seed)));
    check({tag, "_last_x"}, 32'(last_x), 32'd159);
    check({tag, "_last_y"}, 32'(last_y), 32'd119);
    check({tag, "_last_colour"}, 32'(last_c), 32'(pix_colour(159, 119, int'(sel), seed)));
  endtask

  int         en_base;
  int         n;
  logic       g_plot;
  logic [9:0] g_x, g_y;
  logic [2:0] g_c;

  initial begin
    seed = int'($urandom_range(0, 7));
    resetn = 1'b0; key_next = 1'b0; game_over = 1'b0;
    game_plot = 1'b0; game_x = 10'd0; game_y = 10'd0; game_colour = 3'd0;
    exp_sel = 2'd0;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(dut_state), 32'd0);
    check("rst_enable", 32'(bus.scr_enable), 32'd0);
    check("rst_select", 32'(bus.select_screen), 32'd0);
    check("rst_grant", 32'(game_grant), 32'd0);
    check("rst_plot", 32'(bus.vga_plot), 32'd0);
    check("rst_vga_xy", {12'd0, bus.vga_x, bus.vga_y}, 32'd0);
    check("rst_colour", 32'(bus.vga_colour), 32'd0);

    // Title blit after reset release.
    en_base = en_cnt;
    resetn = 1'b1;
    wait_state(3'd2, 25000, "title_reach_show");
    repeat (6) @(negedge clk);
    check_blit("title", 2'd0, en_base);

    // Key rise in T_SHOW: instructions blit.
    exp_sel = 2'd1;
    en_base = en_cnt;
    key_next = 1'b1; @(negedge clk); key_next = 1'b0;
    wait_state(3'd5, 25000, "instr_reach_show");
    repeat (6) @(negedge clk);
    check_blit("instr", 2'd1, en_base);
    check("instr_select_hold", 32'(bus.select_screen), 32'd1);
    check("show_no_grant", 32'(game_grant), 32'd0);

    // Key rise in I_SHOW: GAME with grant from its first cycle.
    key_next = 1'b1; @(negedge clk); key_next = 1'b0;
    check("enter_game_state", 32'(dut_state), 32'd6);
    check("enter_game_grant", 32'(game_grant), 32'd1);
    game_plot = 1'b1; game_x = 10'd80; game_y = 10'd60; game_colour = 3'b111;
    @(negedge clk);
    check("game_px_plot", 32'(bus.vga_plot), 32'd1);
    check("game_px_x", 32'(bus.vga_x), 32'd80);
    check("game_px_y", 32'(bus.vga_y), 32'd60);
    check("game_px_colour", 32'(bus.vga_colour), 32'd7);

    // Randomized game pixels, with key toggles that GAME must ignore.
    for (int i = 0; i < 8; i++) begin
      g_plot = 1'($urandom); g_x = 10'($urandom_range(0, 159));
      g_y = 10'($urandom_range(0, 119)); g_c = 3'($urandom);
      game_plot = g_plot; game_x = g_x; game_y = g_y; game_colour = g_c;
      key_next = ~key_next;
      @(negedge clk);
      check("game_rand_plot", 32'(bus.vga_plot), 32'(g_plot));
      check("game_rand_xy", {12'd0, bus.vga_x, bus.vga_y}, {12'd0, g_x, g_y});
      check("game_rand_colour", 32'(bus.vga_colour), 32'(g_c));
    end
    key_next = 1'b0;
    @(negedge clk);
    check("key_ignored_in_game", 32'(dut_state), 32'd6);

    // game_over together with a game pixel: pixel lands, then title redraw.
    exp_sel = 2'd0;
    en_base = en_cnt;
    game_plot = 1'b1; game_x = 10'd10; game_y = 10'd20; game_colour = 3'd5; game_over = 1'b1;
    @(negedge clk);
    game_over = 1'b0;
    check("over_state", 32'(dut_state), 32'd0);
    check("over_grant", 32'(game_grant), 32'd0);
    check("over_select", 32'(bus.select_screen), 32'd0);
    check("over_last_game_px", {11'd0, bus.vga_plot, bus.vga_x, bus.vga_y}, {11'd0, 1'b1, 10'd10, 10'd20});
    check("over_last_game_colour", 32'(bus.vga_colour), 32'd5);
    n = 0;
    while (dut_state !== 3'd2 && n < 25000) begin
      game_plot = 1'($urandom); game_x = 10'($urandom_range(0, 159));
      game_y = 10'($urandom_range(0, 119)); game_colour = 3'($urandom);
      @(negedge clk);
      n++;
    end
    game_plot = 1'b0;
    check("redraw_reach_show", 32'(dut_state), 32'd2);
    repeat (6) @(negedge clk);
    check_blit("redraw", 2'd0, en_base);

    // Instructions blit interrupted by reset at pixel 5000, key held high.
    exp_sel = 2'd1;
    key_next = 1'b1; @(negedge clk); key_next = 1'b0;
    wait_state(3'd4, 10, "instr2_reach_draw");
    n = 0;
    while (pix_cnt < 5000 && n < 25000) begin
      @(negedge clk);
      n++;
    end
    check("instr2_reach_px5000", 32'(pix_cnt >= 5000), 32'd1);
    resetn = 1'b0; key_next = 1'b1;
    @(negedge clk);
    check("midblit_rst_plot", 32'(bus.vga_plot), 32'd0);
    check("midblit_rst_state", 32'(dut_state), 32'd0);
    check("midblit_rst_select", 32'(bus.select_screen), 32'd0);
    check("midblit_rst_enable", 32'(bus.scr_enable), 32'd0);
    repeat (2) @(negedge clk);
    exp_sel = 2'd0;
    en_base = en_cnt;
    resetn = 1'b1;

    // Fresh title blit; key toggles randomly in T_DRAW, then stays high.
    n = 0;
    while (dut_state !== 3'd2 && n < 25000) begin
      if (pix_cnt < 19000) key_next = 1'($urandom);
      else key_next = 1'b1;
      @(negedge clk);
      n++;
    end
    check("rst_title_reach_show", 32'(dut_state), 32'd2);
    repeat (40) @(negedge clk);
    check("held_key_no_advance", 32'(dut_state), 32'd2);
    check_blit("rst_title", 2'd0, en_base);
    key_next = 1'b0;
    repeat (2) @(negedge clk);
    check("key_release_no_advance", 32'(dut_state), 32'd2);
    key_next = 1'b1;
    @(negedge clk);
    check("fresh_rise_advance", 32'(dut_state), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
